// File: rtl/voice_alloc_pkg.sv
// Shared types and MIDI field widths for the voice allocator.
// Configuration macro VOICE_STEAL_EN is consumed by voice_alloc.sv.
package voice_alloc_pkg;

    localparam int CHAN_W = 4;
    localparam int KEY_W  = 7;
    localparam int VEL_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    typedef struct packed {
        logic              is_on;
        logic [CHAN_W-1:0] chan;
        logic [KEY_W-1:0]  key;
        logic [VEL_W-1:0]  vel;
    } event_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/voice_lru.sv
// Per-voice least-recently-used ages: a permutation of 0..NUM_VOICES-1,
// where the voice holding age NUM_VOICES-1 is the oldest.
module voice_lru
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 32,
    parameter int V_WIDTH    = $clog2(NUM_VOICES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          touch_valid,
    input  logic [V_WIDTH-1:0]            touch_idx,
    output logic [NUM_VOICES*V_WIDTH-1:0] age_vec,
    output logic [V_WIDTH-1:0]            oldest_idx
);

    logic [V_WIDTH-1:0] age_q [NUM_VOICES];
    logic [V_WIDTH-1:0] age_d [NUM_VOICES];
    logic [V_WIDTH-1:0] touch_age;

    // Touching a voice makes it youngest; only voices younger than it age, so ages stay distinct.
    always_comb begin
        age_d     = age_q;
        touch_age = age_q[touch_idx];
        if (touch_valid) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (V_WIDTH'(i) == touch_idx) begin
                    age_d[i] = '0;
                end else if (age_q[i] < touch_age) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                age_q[i] <= V_WIDTH'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        age_vec    = '0;
        oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            age_vec[i*V_WIDTH +: V_WIDTH] = age_q[i];
            if (age_q[i] == V_WIDTH'(NUM_VOICES - 1)) begin
                oldest_idx = V_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: scans one voice per cycle, then issues a voice command.
// Define VOICE_STEAL_EN to steal the oldest voice when none is free; otherwise the note is dropped.
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 32,
    parameter int V_WIDTH    = $clog2(NUM_VOICES)
) (
    input  logic                  reg_clk,
    input  logic                  reset_reg,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_on,
    input  logic [CHAN_W-1:0]     in_chan,
    input  logic [KEY_W-1:0]      in_key,
    input  logic [VEL_W-1:0]      in_vel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [V_WIDTH-1:0]    out_voice,
    output logic [CHAN_W-1:0]     out_chan,
    output logic [KEY_W-1:0]      out_key,
    output logic [VEL_W-1:0]      out_vel,
    output logic                  out_gate,
    output logic                  out_steal,
    input  logic [NUM_VOICES-1:0] release_done,
    output logic [NUM_VOICES-1:0] keys_on,
    output logic [NUM_VOICES-1:0] voice_free,
    output logic [V_WIDTH:0]      active_keys,
    output logic [7:0]            drop_cnt
);

    state_e                state_q, state_d;
    event_t                ev_q, ev_d;
    logic [V_WIDTH-1:0]    scan_idx_q, scan_idx_d;
    logic                  match_found_q, match_found_d;
    logic [V_WIDTH-1:0]    match_idx_q, match_idx_d;
    logic                  free_found_q, free_found_d;
    logic [V_WIDTH-1:0]    free_idx_q, free_idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [V_WIDTH-1:0]    out_voice_q, out_voice_d;
    logic [CHAN_W-1:0]     out_chan_q, out_chan_d;
    logic [KEY_W-1:0]      out_key_q, out_key_d;
    logic [VEL_W-1:0]      out_vel_q, out_vel_d;
    logic                  out_gate_q, out_gate_d;
    logic [NUM_VOICES-1:0] keys_on_q, keys_on_d;
    logic [NUM_VOICES-1:0] voice_free_q, voice_free_d;
    logic [CHAN_W-1:0]     voice_chan_q [NUM_VOICES];
    logic [CHAN_W-1:0]     voice_chan_d [NUM_VOICES];
    logic [KEY_W-1:0]      voice_key_q [NUM_VOICES];
    logic [KEY_W-1:0]      voice_key_d [NUM_VOICES];
    logic [V_WIDTH:0]      active_keys_q, active_keys_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic                  hit, m_found, f_found, do_issue;
    logic [V_WIDTH-1:0]    m_idx, f_idx, sel_idx;
    logic                  touch_valid;
    logic [NUM_VOICES*V_WIDTH-1:0] age_vec;
    logic [V_WIDTH-1:0]    oldest_idx;

`ifdef VOICE_STEAL_EN
    logic                  out_steal_q, out_steal_d;
    logic                  sel_steal;
`endif

    voice_lru #(
        .NUM_VOICES (NUM_VOICES),
        .V_WIDTH    (V_WIDTH)
    ) u_lru (
        .clk         (reg_clk),
        .rst         (reset_reg),
        .touch_valid (touch_valid),
        .touch_idx   (out_voice_q),
        .age_vec     (age_vec),
        .oldest_idx  (oldest_idx)
    );

    always_comb begin
        state_d       = state_q;
        ev_d          = ev_q;
        scan_idx_d    = scan_idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        out_valid_d   = out_valid_q;
        out_voice_d   = out_voice_q;
        out_chan_d    = out_chan_q;
        out_key_d     = out_key_q;
        out_vel_d     = out_vel_q;
        out_gate_d    = out_gate_q;
        keys_on_d     = keys_on_q;
        voice_chan_d  = voice_chan_q;
        voice_key_d   = voice_key_q;
        drop_cnt_d    = drop_cnt_q;
        touch_valid   = 1'b0;
        hit           = 1'b0;
        m_found       = 1'b0;
        f_found       = 1'b0;
        m_idx         = '0;
        f_idx         = '0;
        sel_idx       = '0;
        do_issue      = 1'b0;
`ifdef VOICE_STEAL_EN
        out_steal_d   = out_steal_q;
        sel_steal     = 1'b0;
`endif
        // A release only frees a voice whose key is already up; an allocation below overrides it.
        voice_free_d  = voice_free_q | (release_done & ~keys_on_q);

        active_keys_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            active_keys_d = active_keys_d + (V_WIDTH + 1)'(keys_on_q[i]);
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ev_d.is_on    = in_on & (in_vel != '0);
                    ev_d.chan     = in_chan;
                    ev_d.key      = in_key;
                    ev_d.vel      = in_vel;
                    scan_idx_d    = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    state_d       = ST_SCAN;
                end
            end

            ST_SCAN: begin
                hit = keys_on_q[scan_idx_q]
                      && (voice_chan_q[scan_idx_q] == ev_q.chan)
                      && (voice_key_q[scan_idx_q] == ev_q.key);
                m_found       = match_found_q | hit;
                m_idx         = match_found_q ? match_idx_q : scan_idx_q;
                f_found       = free_found_q | voice_free_q[scan_idx_q];
                f_idx         = free_found_q ? free_idx_q : scan_idx_q;
                match_found_d = m_found;
                match_idx_d   = m_idx;
                free_found_d  = f_found;
                free_idx_d    = f_idx;
                scan_idx_d    = scan_idx_q + 1'b1;

                if (scan_idx_q == V_WIDTH'(NUM_VOICES - 1)) begin
                    if (ev_q.is_on) begin
                        if (m_found) begin
                            do_issue = 1'b1;
                            sel_idx  = m_idx;
                        end else if (f_found) begin
                            do_issue = 1'b1;
                            sel_idx  = f_idx;
                        end else begin
`ifdef VOICE_STEAL_EN
                            do_issue  = 1'b1;
                            sel_idx   = oldest_idx;
                            sel_steal = 1'b1;
`else
                            drop_cnt_d = sat_inc8(drop_cnt_q);
`endif
                        end
                    end else if (m_found) begin
                        do_issue = 1'b1;
                        sel_idx  = m_idx;
                    end

                    if (do_issue) begin
                        state_d     = ST_ISSUE;
                        out_valid_d = 1'b1;
                        out_voice_d = sel_idx;
                        out_chan_d  = ev_q.chan;
                        out_key_d   = ev_q.key;
                        out_vel_d   = ev_q.vel;
                        out_gate_d  = ev_q.is_on;
`ifdef VOICE_STEAL_EN
                        out_steal_d = sel_steal;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_ISSUE: begin
                // Voice bookkeeping commits only when the consumer accepts the command.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    if (out_gate_q) begin
                        keys_on_d[out_voice_q]    = 1'b1;
                        voice_free_d[out_voice_q] = 1'b0;
                        voice_chan_d[out_voice_q] = out_chan_q;
                        voice_key_d[out_voice_q]  = out_key_q;
                        touch_valid               = 1'b1;
                    end else begin
                        keys_on_d[out_voice_q] = 1'b0;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            state_q       <= ST_IDLE;
            ev_q          <= '0;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            out_valid_q   <= 1'b0;
            out_voice_q   <= '0;
            out_chan_q    <= '0;
            out_key_q     <= '0;
            out_vel_q     <= '0;
            out_gate_q    <= 1'b0;
            keys_on_q     <= '0;
            voice_free_q  <= '1;
            active_keys_q <= '0;
            drop_cnt_q    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_chan_q[i] <= '0;
                voice_key_q[i]  <= '0;
            end
`ifdef VOICE_STEAL_EN
            out_steal_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ev_q          <= ev_d;
            scan_idx_q    <= scan_idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            out_valid_q   <= out_valid_d;
            out_voice_q   <= out_voice_d;
            out_chan_q    <= out_chan_d;
            out_key_q     <= out_key_d;
            out_vel_q     <= out_vel_d;
            out_gate_q    <= out_gate_d;
            keys_on_q     <= keys_on_d;
            voice_free_q  <= voice_free_d;
            active_keys_q <= active_keys_d;
            drop_cnt_q    <= drop_cnt_d;
            voice_chan_q  <= voice_chan_d;
            voice_key_q   <= voice_key_d;
`ifdef VOICE_STEAL_EN
            out_steal_q   <= out_steal_d;
`endif
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = out_valid_q;
    assign out_voice   = out_voice_q;
    assign out_chan    = out_chan_q;
    assign out_key     = out_key_q;
    assign out_vel     = out_vel_q;
    assign out_gate    = out_gate_q;
    assign keys_on     = keys_on_q;
    assign voice_free  = voice_free_q;
    assign active_keys = active_keys_q;
    assign drop_cnt    = drop_cnt_q;

`ifdef VOICE_STEAL_EN
    assign out_steal = out_steal_q;
    logic unused_lru;
    assign unused_lru = ^age_vec;
`else
    assign out_steal = 1'b0;
    logic unused_lru;
    assign unused_lru = ^{age_vec, oldest_idx};
`endif

endmodule
